// File: rtl/dram_pkg.sv
// Shared constants for the dram responder: FSM state encodings, error classes
// and default parameter values.
package dram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_LATENCY    = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Error class captured at acceptance; only "none vs. other" reaches the bus.
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BOTH  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

endpackage

// File: rtl/dram_array.sv
// Word-organised storage: synchronous write port, asynchronous read port.
module dram_array
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset; clearing it would prevent RAM inference
    // and the core must never rely on power-up contents anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dram_responder.sv
// Clocked multi-cycle data-memory slave for the core's dram bus, with a
// one-cycle ready pulse and an error flag for illegal requests.
module dram_responder
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        dram_read,
    input  logic        dram_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        dram_ready,
    output logic        dram_err
);

    logic [1:0]            state;
    logic [3:0]            counter;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_data;
    logic                  lat_write;
    logic [1:0]            lat_err;
    logic [1:0]            err_class;
    logic                  access;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        err_class = ERR_NONE;
        if (dram_read && dram_write) begin
            err_class = ERR_BOTH;
        end else if (address[1:0] != 2'b00) begin
            err_class = ERR_ALIGN;
        end else if (|address[31:ADDR_WIDTH+2]) begin
            err_class = ERR_RANGE;
        end
    end

    // The access happens on the edge that leaves WAIT with the counter spent.
    assign access = (state == S_WAIT) && (counter == 4'd0);
    assign mem_we = access && lat_write && (lat_err == ERR_NONE);

    dram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (lat_addr),
        .raddr (lat_addr),
        .wdata (lat_data),
        .rdata (mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            counter    <= 4'd0;
            lat_addr   <= '0;
            lat_data   <= 32'h0;
            lat_write  <= 1'b0;
            lat_err    <= ERR_NONE;
            read_data  <= 32'h0;
            dram_ready <= 1'b0;
            dram_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dram_read || dram_write) begin
                        lat_addr  <= address[ADDR_WIDTH+1:2];
                        lat_data  <= write_data;
                        lat_write <= dram_write;
                        lat_err   <= err_class;
                        counter   <= 4'(LATENCY - 1);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        state      <= S_RESP;
                        dram_ready <= 1'b1;
                        dram_err   <= (lat_err != ERR_NONE);
                        if (!lat_write) begin
                            read_data <= (lat_err != ERR_NONE) ? 32'h0 : mem_rdata;
                        end
                    end
                end
                S_RESP: begin
                    dram_ready <= 1'b0;
                    dram_err   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench: LATENCY=2 instance for function/error/reset cases and a
// LATENCY=1 instance for back-to-back throughput with a held request.
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        dram_read;
    logic        dram_write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        dram_ready;
    logic        dram_err;

    logic [31:0] address1;
    logic        dram_read1;
    logic        dram_write1;
    logic [31:0] write_data1;
    logic [31:0] read_data1;
    logic        dram_ready1;
    logic        dram_err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .dram_read  (dram_read),
        .dram_write (dram_write),
        .write_data (write_data),
        .read_data  (read_data),
        .dram_ready (dram_ready),
        .dram_err   (dram_err)
    );

    dram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .address    (address1),
        .dram_read  (dram_read1),
        .dram_write (dram_write1),
        .write_data (write_data1),
        .read_data  (read_data1),
        .dram_ready (dram_ready1),
        .dram_err   (dram_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and hold it until ready; latency counts falling edges
    // after the request is presented (acceptance edge + LATENCY => 3 for L=2).
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, output int lat, output logic err,
                       output logic [31:0] rdata);
        bit got = 0;
        lat   = -1;
        err   = 1'bx;
        rdata = 32'hx;
        @(negedge clk);
        dram_read  = rd;
        dram_write = wr;
        address    = addr;
        write_data = data;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (dram_ready) begin
                got   = 1;
                lat   = i;
                err   = dram_err;
                rdata = read_data;
            end
        end
        dram_read  = 1'b0;
        dram_write = 1'b0;
    endtask

    int          lat;
    logic        err;
    logic [31:0] rd;
    logic [6:0]  pulses;
    bit          saw_ready;

    initial begin
        reset       = 1'b1;
        address     = 32'h0;
        dram_read   = 1'b0;
        dram_write  = 1'b0;
        write_data  = 32'h0;
        address1    = 32'h0;
        dram_read1  = 1'b0;
        dram_write1 = 1'b0;
        write_data1 = 32'h0;

        repeat (2) @(negedge clk);
        check("reset_ready", {31'b0, dram_ready}, 32'h0);
        check("reset_err", {31'b0, dram_err}, 32'h0);
        check("reset_read_data", read_data, 32'h0);
        reset = 1'b0;

        // Basic write then read-after-write.
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, rd);
        check("wr10_latency", 32'(lat), 32'd3);
        check("wr10_err", {31'b0, err}, 32'h0);
        check("wr10_read_data_unchanged", rd, 32'h0);
        @(negedge clk);
        check("wr10_ready_one_cycle", {31'b0, dram_ready}, 32'h0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("rd10_latency", 32'(lat), 32'd3);
        check("rd10_err", {31'b0, err}, 32'h0);
        check("rd10_data", rd, 32'hDEADBEEF);

        // Misaligned read forces zero; aligned word still intact.
        txn(1'b1, 1'b0, 32'h13, 32'h0, lat, err, rd);
        check("rd13_latency", 32'(lat), 32'd3);
        check("rd13_err", {31'b0, err}, 32'h1);
        check("rd13_data_zero", rd, 32'h0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("rd10_again", rd, 32'hDEADBEEF);

        // Read and write together is an error and must not write.
        txn(1'b0, 1'b1, 32'h20, 32'h11112222, lat, err, rd);
        check("wr20_err", {31'b0, err}, 32'h0);
        txn(1'b1, 1'b1, 32'h20, 32'h00001234, lat, err, rd);
        check("both20_err", {31'b0, err}, 32'h1);
        check("both20_latency", 32'(lat), 32'd3);
        check("both20_read_data_held", rd, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'h20, 32'h0, lat, err, rd);
        check("rd20_unchanged", rd, 32'h11112222);

        // Out-of-range write must not alias onto word 0.
        txn(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, lat, err, rd);
        txn(1'b0, 1'b1, 32'h1000, 32'h55555555, lat, err, rd);
        check("wr1000_err", {31'b0, err}, 32'h1);
        txn(1'b1, 1'b0, 32'h0, 32'h0, lat, err, rd);
        check("rd0_not_aliased", rd, 32'hA5A5A5A5);

        // Changes to inputs after acceptance are ignored.
        txn(1'b0, 1'b1, 32'h40, 32'h0BADF00D, lat, err, rd);
        @(negedge clk);
        address    = 32'h50;
        write_data = 32'h77778888;
        dram_write = 1'b1;
        @(posedge clk);
        #1;
        address    = 32'h60;
        write_data = 32'h99990000;
        dram_write = 1'b0;
        dram_read  = 1'b1;
        repeat (3) @(negedge clk);
        dram_read = 1'b0;
        check("late_change_err", {31'b0, dram_err}, 32'h0);
        txn(1'b1, 1'b0, 32'h50, 32'h0, lat, err, rd);
        check("rd50_latched_data", rd, 32'h77778888);

        // Reset one cycle after acceptance aborts the write asynchronously.
        @(negedge clk);
        address    = 32'h40;
        write_data = 32'hCAFE0000;
        dram_write = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_ready_async", {31'b0, dram_ready}, 32'h0);
        check("abort_err_async", {31'b0, dram_err}, 32'h0);
        check("abort_read_data_async", read_data, 32'h0);
        saw_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dram_ready) saw_ready = 1;
        end
        dram_write = 1'b0;
        reset      = 1'b0;
        check("abort_no_ready", {31'b0, saw_ready}, 32'h0);
        txn(1'b1, 1'b0, 32'h40, 32'h0, lat, err, rd);
        check("rd40_old_value", rd, 32'h0BADF00D);

        // LATENCY=1 with the read held continuously: pulses 3 cycles apart.
        @(negedge clk);
        address1   = 32'h0;
        dram_read1 = 1'b1;
        pulses     = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pulses[i] = dram_ready1;
            if (dram_ready1) check("l1_err", {31'b0, dram_err1}, 32'h0);
        end
        dram_read1 = 1'b0;
        check("l1_pulse_pattern", {25'b0, pulses}, 32'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
